// File: rtl/fifo_d1_pkg.sv
// Shared sizing helpers and parameter legality checks for the fifo_ctrl_d1 slice.
package fifo_d1_pkg;

    localparam int unsigned DEF_ADDR_W   = 3;
    localparam int unsigned DEF_AF_LEVEL = 6;
    localparam int unsigned DEF_AE_LEVEL = 1;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

    // Count needs one extra bit to represent a completely full FIFO.
    function automatic int unsigned cnt_w_of(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit af_level_ok(input int unsigned lvl, input int unsigned depth);
        return (lvl >= 1) && (lvl <= depth);
    endfunction

    function automatic bit ae_level_ok(input int unsigned lvl, input int unsigned depth);
        return lvl <= depth - 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_d1.sv
// Wrapping ADDR_W-bit RAM pointer with synchronous reset, clear and increment.
module fifo_ptr_d1 #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_d1.sv
// Pointer, occupancy and flag controller for the main-FIFO RAM (first-word-fall-through).
// Optional FIFO_ERR_FLAGS_EN adds registered overflow/underflow pulse outputs.
module fifo_ctrl_d1
    import fifo_d1_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              data_valid
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);
    localparam int unsigned CNT_W = cnt_w_of(ADDR_W);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_af_illegal
        $error("fifo_ctrl_d1: AF_LEVEL must lie in 1..DEPTH");
    end
    if (!ae_level_ok(AE_LEVEL, DEPTH)) begin : g_ae_illegal
        $error("fifo_ctrl_d1: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;
    logic             kill;

    // A full FIFO still accepts a push when a pop frees the slot at the same edge.
    assign kill    = reset | flush;
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign wr_en   = push_ok & ~kill;
    assign rd_en   = pop_ok & ~kill;

    fifo_ptr_d1 #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .reset_i (reset),
        .clr_i   (flush),
        .inc_i   (push_ok),
        .ptr_o   (wr_ptr)
    );

    fifo_ptr_d1 #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk     (clk),
        .reset_i (reset),
        .clr_i   (flush),
        .inc_i   (pop_ok),
        .ptr_o   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags are pure decodes of the registered count.
    assign count        = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign data_valid   = ~empty;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (kill) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= push & ~push_ok;
            underflow_q <= pop & ~pop_ok;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_d1.sv
// Randomized self-checking bench for fifo_ctrl_d1 against a queue-based FIFO model.
module tb_fifo_ctrl_d1;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       reset, flush, push, pop;
    logic       wr_en, rd_en, full, empty, almost_full, almost_empty, data_valid;
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    fifo_ctrl_d1 dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_valid   (data_valid)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM addressed by the DUT, so head data reflects pointer correctness.
    logic [15:0] mem [DEPTH];
    logic [15:0] wdata;
    always @(posedge clk) if (wr_en) mem[wr_ptr] <= wdata;

    logic [15:0] model_q [$];
    int          n_pushed, n_popped;
    bit          exp_ovf, exp_unf;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step(input bit r, input bit f, input bit pu, input bit po);
        int  sz;
        bit  epush, epop, kill;
        @(negedge clk);
        reset = r; flush = f; push = pu; pop = po;
        wdata = wdata + 16'd1;
        #1;
        sz = model_q.size();
        check("count", 32'(count), 32'(sz));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("empty", 32'(empty), 32'(sz == 0));
        check("almost_full", 32'(almost_full), 32'(sz >= AF));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        check("data_valid", 32'(data_valid), 32'(sz != 0));
        check("wr_ptr", 32'(wr_ptr), 32'(n_pushed % DEPTH));
        check("rd_ptr", 32'(rd_ptr), 32'(n_popped % DEPTH));
        if (sz != 0) check("head_data", 32'(mem[rd_ptr]), 32'(model_q[0]));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_unf));
`endif
        kill  = r || f;
        epush = pu && (sz < DEPTH || po);
        epop  = po && (sz > 0);
        check("wr_en", 32'(wr_en), 32'(epush && !kill));
        check("rd_en", 32'(rd_en), 32'(epop && !kill));
        @(posedge clk);
        if (kill) begin
            model_q.delete();
            n_pushed = 0;
            n_popped = 0;
        end else begin
            if (epop) begin
                void'(model_q.pop_front());
                n_popped++;
            end
            if (epush) begin
                model_q.push_back(wdata);
                n_pushed++;
            end
        end
        exp_ovf = !kill && pu && !epush;
        exp_unf = !kill && po && !epop;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; wdata = 16'h100;
        n_pushed = 0; n_popped = 0; exp_ovf = 0; exp_unf = 0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // Fill past full, then drain past empty.
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // Full with simultaneous push and pop, then drain to see the new word last.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        // Empty with simultaneous push and pop.
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        // Fill to 5, then random traffic across the pointer wrap.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        // Flush with a push pending at count 4.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 1, 1, 1);
        step(0, 0, 0, 0);
        // Reset mid-burst.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(1, 0, 1, 1);
        step(0, 0, 0, 0);
        // Long random run with occasional flush and reset.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50));
        end
        step(0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_d1.md
Name: fifo_ctrl_d1

Overview:
Pointer and flag controller for the main-FIFO RAM macro.
- Accepts push/pop requests and drives the RAM's write enable, read enable, wr_ptr and rd_ptr.
- Tracks occupancy and produces full, empty and almost-full/almost-empty flags.
- The RAM read path is combinational from rd_ptr, so the head word is visible whenever the FIFO is not empty (first-word-fall-through).

Parameters:
- ADDR_W, 3, address/pointer width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of pointers and count; contents untouched
- push  in  1  write request
- pop  in  1  read request; the head word is consumed at this edge
- wr_en  out  1  RAM write enable (combinational)
- rd_en  out  1  RAM read enable (combinational)
- wr_ptr  out  ADDR_W  RAM write address (registered)
- rd_ptr  out  ADDR_W  RAM read address (registered)
- count  out  ADDR_W+1  occupancy, 0..DEPTH (registered)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- data_valid  out  1  equals ~empty; the RAM data_out is a valid head word

Behaviour:
- Reset (highest priority):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0, data_valid=0.
- Flush (second priority, when reset=0): same register values as reset.
  - wr_en and rd_en are forced to 0 in that cycle.
  - Any push/pop presented in that cycle is dropped.
- Acceptance (combinational, same cycle):
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
  - wr_en = push_ok & ~reset & ~flush.
  - rd_en = pop_ok & ~reset & ~flush.
- Pointer update at the edge:
  - wr_ptr increments when push_ok; rd_ptr increments when pop_ok.
  - Both wrap modulo DEPTH (natural ADDR_W overflow).
- Count update:
  - +1 on push_ok only; -1 on pop_ok only.
  - Unchanged on both or neither.
  - Never leaves 0..DEPTH.
- All flags decode from the count register; they change in the cycle after the accepting edge.
- Simultaneous push+pop when full:
  - Both accepted; count stays DEPTH.
  - The write lands at the slot being vacated. The read returns the old word because the RAM write is edge-registered.
- Simultaneous push+pop when empty:
  - Pop rejected, push accepted; count becomes 1.
  - The new word is visible at the head in the next cycle.
- Push when full without pop: ignored; pointers and count hold, wr_en=0.
- Pop when empty: ignored; rd_en=0.
- Latency:
  - A word pushed at edge N is readable at the head from cycle N+1.
  - Pop at edge M makes the next word visible from cycle M+1.
- Reset or flush mid-burst: takes effect at that edge. Nothing from that cycle is committed.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: adds output ports overflow (1) and underflow (1), both registered.
  - overflow pulses one cycle after the edge where push=1 was rejected.
  - underflow pulses one cycle after the edge where pop=1 was rejected.
  - Both are cleared by reset and flush.
- Undefined: the ports do not exist; rejected requests are silently ignored. All other behaviour is identical.

Decomposition:
- Package fifo_d1_pkg:
  - DEPTH computation from ADDR_W.
  - Pointer and count width constants.
  - Parameter legality checks for AF_LEVEL and AE_LEVEL (elaboration-time error if out of range).
- Sub-module fifo_ptr_d1, instantiated twice (write side, read side):
  - Wrapping ADDR_W counter with synchronous reset, clear (driven by flush) and increment inputs.
- Top level holds acceptance logic, count register and flag decode.

Test Plan:
- Reset then idle → ptrs 0, count 0, empty=1, almost_empty=1, full=0, wr_en=rd_en=0.
- Push 8 words (DEPTH=8) → count 8, full=1, almost_full from count 6, wr_ptr back to 0; 9th push gives wr_en=0, count stays 8, overflow pulse (macro on).
- Pop 8 words from full → data read out in push order, empty=1 after the last pop, rd_ptr=0; extra pop gives rd_en=0 and an underflow pulse.
- Full + push&pop same cycle → wr_en=rd_en=1, count stays 8, old head read out, new word read 8 pops later; empty + push&pop → only wr_en=1, count 1.
- Fill to 5, then pointer wrap-around over 20 mixed random push/pop cycles → count always equals the scoreboard model, data order preserved across the wrap.
- Flush asserted with push=1 at count 4 → next cycle count 0, ptrs 0, empty=1, wr_en=0 during the flush cycle.
